// File: rtl/led_blink_sequencer_if.sv
// Command bus for led_blink_sequencer.
// A host (UART decoder, button decoder) drives a command. The sequencer
// accepts it on any clock edge where cmd_valid and cmd_ready are both high.
//   cmd_valid  : command present (host -> sequencer)
//   cmd_ready  : sequencer can accept a command (sequencer -> host)
//   cmd_led    : target LED index, 3 bits
//   cmd_mode   : 0 = OFF, 1 = ON, 2 = BLINK, 3 = PULSE
//   cmd_period : half-period in base ticks; 0 behaves as 1
//   cmd_count  : number of on-pulses, used by PULSE only
interface led_blink_sequencer_if #(
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned COUNT_W  = 8
) ();
  logic                cmd_valid;
  logic                cmd_ready;
  logic [2:0]          cmd_led;
  logic [1:0]          cmd_mode;
  logic [PERIOD_W-1:0] cmd_period;
  logic [COUNT_W-1:0]  cmd_count;

  modport master (
    output cmd_valid, cmd_led, cmd_mode, cmd_period, cmd_count,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_led, cmd_mode, cmd_period, cmd_count,
    output cmd_ready
  );
endinterface

// File: rtl/led_blink_sequencer.sv
// Command-driven LED controller. Each LED channel can be OFF, ON, BLINK, or
// PULSE (a burst of N on-pulses). A shared prescaler produces one base tick
// every TICK_DIV clocks. Each channel has its own half-period timer.
//   clk     : system clock
//   rst_n   : synchronous, active-low reset
//   cmd     : command bus (slave side); see led_blink_sequencer_if
//   led     : LED drive, 1 = lit
//   busy    : channel is in BLINK, or its PULSE burst has not finished
//   done    : 1-cycle strobe when a PULSE burst completes
//   cmd_err : 1-cycle strobe when an accepted command targeted a missing LED
// A command accepted at edge N is registered first, then applied at edge N+1.
// All outputs are registered.
module led_blink_sequencer #(
  parameter int unsigned NUM_LEDS = 2,
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned COUNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  led_blink_sequencer_if.slave  cmd,
  output logic [NUM_LEDS-1:0]   led,
  output logic [NUM_LEDS-1:0]   busy,
  output logic [NUM_LEDS-1:0]   done,
  output logic                  cmd_err
);

  localparam int unsigned PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_PULSE = 2'd3;

  typedef enum logic [2:0] {
    StOff,
    StOn,
    StBlink,
    StPulseOn,
    StPulseOff
  } ch_state_e;

  logic [PRESC_W-1:0]  presc;
  logic                tick;
  logic                ready;
  logic                accept;

  // Registered copy of the accepted command, applied one edge later.
  logic                pend_valid;
  logic [2:0]          pend_led;
  logic [1:0]          pend_mode;
  logic [PERIOD_W-1:0] pend_period;
  logic [COUNT_W-1:0]  pend_count;
  logic [PERIOD_W-1:0] eff_period;
  logic [NUM_LEDS-1:0] pend_hit;
  logic                pend_oob;

  ch_state_e           state     [NUM_LEDS];
  logic [PERIOD_W-1:0] timer     [NUM_LEDS];
  logic [PERIOD_W-1:0] reload    [NUM_LEDS];
  logic [COUNT_W-1:0]  remaining [NUM_LEDS];

  assign cmd.cmd_ready = ready;

  always_comb begin
    tick       = (presc == PRESC_MAX);
    accept     = cmd.cmd_valid & ready;
    eff_period = (pend_period == '0) ? PERIOD_W'(1) : pend_period;
    pend_oob   = pend_valid && ({29'd0, pend_led} >= NUM_LEDS);
    pend_hit   = '0;
    for (int i = 0; i < int'(NUM_LEDS); i++) begin
      pend_hit[i] = pend_valid && (pend_led == 3'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc       <= '0;
      ready       <= 1'b0;
      pend_valid  <= 1'b0;
      pend_led    <= '0;
      pend_mode   <= '0;
      pend_period <= '0;
      pend_count  <= '0;
      cmd_err     <= 1'b0;
      led         <= '0;
      busy        <= '0;
      done        <= '0;
      for (int i = 0; i < int'(NUM_LEDS); i++) begin
        state[i]     <= StOff;
        timer[i]     <= '0;
        reload[i]    <= '0;
        remaining[i] <= '0;
      end
    end else begin
      presc      <= tick ? '0 : presc + PRESC_W'(1);
      ready      <= 1'b1;
      pend_valid <= accept;
      if (accept) begin
        pend_led    <= cmd.cmd_led;
        pend_mode   <= cmd.cmd_mode;
        pend_period <= cmd.cmd_period;
        pend_count  <= cmd.cmd_count;
      end
      cmd_err <= pend_oob;

      for (int i = 0; i < int'(NUM_LEDS); i++) begin
        done[i] <= 1'b0;
        if (pend_hit[i]) begin
          // A new command always wins over a timer expiry in the same cycle.
          timer[i]     <= eff_period;
          reload[i]    <= eff_period;
          remaining[i] <= pend_count;
          unique case (pend_mode)
            MODE_OFF: begin
              state[i] <= StOff;
              led[i]   <= 1'b0;
              busy[i]  <= 1'b0;
            end
            MODE_ON: begin
              state[i] <= StOn;
              led[i]   <= 1'b1;
              busy[i]  <= 1'b0;
            end
            MODE_BLINK: begin
              state[i] <= StBlink;
              led[i]   <= 1'b1;
              busy[i]  <= 1'b1;
            end
            MODE_PULSE: begin
              if (pend_count == '0) begin
                // An empty burst completes at once.
                state[i] <= StOff;
                led[i]   <= 1'b0;
                busy[i]  <= 1'b0;
                done[i]  <= 1'b1;
              end else begin
                state[i] <= StPulseOn;
                led[i]   <= 1'b1;
                busy[i]  <= 1'b1;
              end
            end
          endcase
        end else if (tick && (state[i] == StBlink || state[i] == StPulseOn ||
                              state[i] == StPulseOff)) begin
          // Timer holds 1..eff_period while timed; expiry is the tick seen at 1.
          if (timer[i] != PERIOD_W'(1)) begin
            timer[i] <= timer[i] - PERIOD_W'(1);
          end else begin
            timer[i] <= reload[i];
            case (state[i])
              StBlink: led[i] <= ~led[i];
              StPulseOn: begin
                state[i]     <= StPulseOff;
                led[i]       <= 1'b0;
                remaining[i] <= remaining[i] - COUNT_W'(1);
              end
              StPulseOff: begin
                if (remaining[i] == '0) begin
                  state[i] <= StOff;
                  busy[i]  <= 1'b0;
                  done[i]  <= 1'b1;
                end else begin
                  state[i] <= StPulseOn;
                  led[i]   <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Self-checking bench for led_blink_sequencer (TICK_DIV=4, NUM_LEDS=2).
// A reference model runs on every clock edge. It tracks the last command
// applied to each channel and works out the expected outputs directly:
// it counts the base ticks since the command took effect and divides by
// the half-period to get the phase. It pushes one expected record per edge
// into a queue. A separate monitor pops a record at each falling edge and
// compares it with the DUT outputs.
module tb_led_blink_sequencer;
  localparam int unsigned NUM_LEDS = 2;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned PERIOD_W = 16;
  localparam int unsigned COUNT_W  = 8;
  localparam int          NL       = int'(NUM_LEDS);
  localparam int          TD       = int'(TICK_DIV);

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NUM_LEDS-1:0] led;
  logic [NUM_LEDS-1:0] busy;
  logic [NUM_LEDS-1:0] done;
  logic                cmd_err;

  led_blink_sequencer_if #(.PERIOD_W(PERIOD_W), .COUNT_W(COUNT_W)) cmd_bus ();

  led_blink_sequencer #(
    .NUM_LEDS(NUM_LEDS),
    .TICK_DIV(TICK_DIV),
    .PERIOD_W(PERIOD_W),
    .COUNT_W (COUNT_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cmd    (cmd_bus),
    .led    (led),
    .busy   (busy),
    .done   (done),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode;
    int a;    // edge at which the command took effect
    int eff;
    int cnt;
  } chan_t;

  typedef struct packed {
    logic                ready;
    logic                err;
    logic [NUM_LEDS-1:0] done;
    logic [NUM_LEDS-1:0] busy;
    logic [NUM_LEDS-1:0] led;
  } exp_t;

  exp_t  exp_q[$];
  chan_t ch[NUM_LEDS];
  int    edge_n   = 0;
  int    rst_edge = 0;
  bit    m_ready  = 0;
  bit    pend_v   = 0;
  int    pend_led, pend_mode, pend_eff, pend_cnt;
  int    n_cmp = 0;
  int    n_bad = 0;

  // Expected outputs of one channel after edge e.
  // Ticks happen on edges e where (e - rst_edge) is a multiple of TICK_DIV.
  function automatic void chan_out(input chan_t c, input int e,
                                   output bit l, output bit b, output bit d);
    int ft, nt, p;
    bit at_bnd;
    l = 0; b = 0; d = 0;
    if (c.mode == 1) begin
      l = 1;
    end else if (c.mode >= 2) begin
      ft     = c.a + TD - ((c.a - rst_edge) % TD);
      nt     = (e < ft) ? 0 : (e - ft) / TD + 1;
      p      = nt / c.eff;
      at_bnd = (nt > 0) && (nt % c.eff == 0) && ((e - rst_edge) % TD == 0);
      if (c.mode == 2) begin
        l = (p % 2 == 0);
        b = 1;
      end else if (c.cnt == 0) begin
        d = (e == c.a);
      end else if (p < 2 * c.cnt) begin
        l = (p % 2 == 0);
        b = 1;
      end else begin
        d = (p == 2 * c.cnt) && at_bnd;
      end
    end
  endfunction

  // Reference model.
  initial begin
    exp_t x;
    bit l, b, d;
    forever begin
      @(posedge clk);
      edge_n++;
      x = '0;
      if (!rst_n) begin
        rst_edge = edge_n;
        pend_v   = 0;
        m_ready  = 0;
        for (int c = 0; c < NL; c++) ch[c] = '{0, edge_n, 1, 0};
      end else begin
        if (pend_v) begin
          if (pend_led >= NL) x.err = 1'b1;
          else ch[pend_led] = '{pend_mode, edge_n, pend_eff, pend_cnt};
        end
        pend_v = m_ready && (cmd_bus.cmd_valid === 1'b1);
        if (pend_v) begin
          pend_led  = int'(cmd_bus.cmd_led);
          pend_mode = int'(cmd_bus.cmd_mode);
          pend_eff  = (cmd_bus.cmd_period == 0) ? 1 : int'(cmd_bus.cmd_period);
          pend_cnt  = int'(cmd_bus.cmd_count);
        end
        m_ready = 1;
        x.ready = 1'b1;
        for (int c = 0; c < NL; c++) begin
          chan_out(ch[c], edge_n, l, b, d);
          x.led[c]  = l;
          x.busy[c] = b;
          x.done[c] = d;
        end
      end
      exp_q.push_back(x);
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %b, expected %b", name, edge_n, act, req);
    end
  endtask

  // Monitor: compare DUT against the scoreboard once per cycle.
  initial begin
    exp_t x;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_empty at edge %0d: got 0 entries, expected 1", edge_n);
      end else begin
        x = exp_q.pop_front();
        check("led",       8'(led),               8'(x.led));
        check("busy",      8'(busy),              8'(x.busy));
        check("done",      8'(done),              8'(x.done));
        check("cmd_err",   8'(cmd_err),           8'(x.err));
        check("cmd_ready", 8'(cmd_bus.cmd_ready), 8'(x.ready));
      end
    end
  end

  // Drive one command for one cycle. Call this at a falling edge.
  task automatic send(input int l, input int m, input int per, input int cnt);
    cmd_bus.cmd_valid  = 1'b1;
    cmd_bus.cmd_led    = 3'(l);
    cmd_bus.cmd_mode   = 2'(m);
    cmd_bus.cmd_period = PERIOD_W'(per);
    cmd_bus.cmd_count  = COUNT_W'(cnt);
    @(negedge clk);
    cmd_bus.cmd_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stimulus.
  initial begin
    cmd_bus.cmd_valid  = 1'b0;
    cmd_bus.cmd_led    = '0;
    cmd_bus.cmd_mode   = '0;
    cmd_bus.cmd_period = '0;
    cmd_bus.cmd_count  = '0;
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    idle(20);

    send(1, 1, 0, 0);          // LED1 ON
    idle(10);
    send(1, 0, 0, 0);          // LED1 OFF
    idle(5);

    send(0, 2, 3, 0);          // BLINK period 3
    idle(100);

    send(0, 3, 2, 3);          // PULSE period 2, three pulses
    idle(70);

    send(0, 3, 1, 0);          // PULSE with count 0
    idle(5);
    send(5, 1, 1, 1);          // out-of-range LED
    idle(5);

    send(0, 2, 1, 0);          // BLINK period 1
    idle(6);
    // Time the next command so it lands on a toggle tick.
    while ((edge_n + 2 - rst_edge) % TD != 0) @(negedge clk);
    send(0, 3, 2, 2);
    idle(10);
    rst_n = 1'b0;              // reset mid-burst
    idle(2);
    rst_n = 1'b1;
    idle(10);

    send(1, 3, 1, 255);        // longest burst, preempted part-way
    idle(120);
    send(1, 0, 0, 0);
    idle(5);

    repeat (400) begin
      if ($urandom_range(3) == 0) begin
        cmd_bus.cmd_valid  = 1'b1;
        cmd_bus.cmd_led    = ($urandom_range(7) == 0) ? 3'($urandom_range(7, 2))
                                                      : 3'($urandom_range(1));
        cmd_bus.cmd_mode   = 2'($urandom_range(3));
        cmd_bus.cmd_period = PERIOD_W'($urandom_range(3));
        cmd_bus.cmd_count  = COUNT_W'($urandom_range(3));
      end else begin
        cmd_bus.cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    cmd_bus.cmd_valid = 1'b0;
    idle(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected stimulus to complete");
    $fatal(1, "watchdog expired");
  end

endmodule
